// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, grant encoding
// and the arbitration decision.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_INSTR = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE  = 2'b00;
  localparam logic [1:0] GRANT_INSTR = 2'b01;
  localparam logic [1:0] GRANT_DATA  = 2'b10;

  // Data has priority unless instruction fetch has been passed over too often.
  function automatic arb_state_t arb_pick(input logic req_i, input logic req_d,
                                          input logic starved);
    if (req_i && req_d) return starved ? ARB_INSTR : ARB_DATA;
    if (req_d)          return ARB_DATA;
    if (req_i)          return ARB_INSTR;
    return ARB_IDLE;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Classic Wishbone signal bundle; MASTER drives the request, SLAVE returns
// the response.
interface wishbone #(
  parameter int unsigned XLEN = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [XLEN/8-1:0] sel;
  logic [XLEN-1:0]   adr;
  logic [XLEN-1:0]   dat_w;
  logic [XLEN-1:0]   dat_r;
  logic              ack;
  logic              err;

  modport MASTER (output cyc, stb, we, sel, adr, dat_w,
                  input  dat_r, ack, err);
  modport SLAVE  (input  cyc, stb, we, sel, adr, dat_w,
                  output dat_r, ack, err);
endinterface

// File: rtl/bus_watchdog.sv
// Saturating cycle counter that flags expiry on the LIMIT-th consecutive
// enabled cycle; LIMIT=0 disables it.
module bus_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned   W    = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [W-1:0]  LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [W-1:0] cnt;
  logic         at_last;

  assign at_last = (cnt == LAST);
  assign expire  = (LIMIT != 0) && en && at_last;

  always_ff @(posedge clk) begin
    if (rst || clr || expire) begin
      cnt <= '0;
    end else if (en && !at_last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one Wishbone bus between instruction and data masters with data
// priority, instruction anti-starvation and an unacknowledged-access watchdog.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  wishbone.SLAVE      instr_bus,
  wishbone.SLAVE      data_bus,
  wishbone.MASTER     mem_bus,
  output logic [1:0]  grant,
  output logic        timeout
);

  localparam int unsigned  SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t        state, next_state, picked;
  logic [SW-1:0]     starve_cnt;
  logic              req_i, req_d, starved;
  logic              granted, release_bus, arb_now, expire;
  logic              wd_en, wd_clr;

  logic              own_cyc, own_stb, own_we;
  logic [XLEN/8-1:0] own_sel;
  logic [XLEN-1:0]   own_adr, own_dat_w;

  assign req_i   = instr_bus.cyc & instr_bus.stb;
  assign req_d   = data_bus.cyc & data_bus.stb;
  assign starved = (starve_cnt == STARVE_MAX);

  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_sel   = '0;
    own_adr   = '0;
    own_dat_w = '0;
    unique case (state)
      ARB_INSTR: begin
        own_cyc   = instr_bus.cyc;
        own_stb   = instr_bus.stb;
        own_we    = instr_bus.we;
        own_sel   = instr_bus.sel;
        own_adr   = instr_bus.adr;
        own_dat_w = instr_bus.dat_w;
      end
      ARB_DATA: begin
        own_cyc   = data_bus.cyc;
        own_stb   = data_bus.stb;
        own_we    = data_bus.we;
        own_sel   = data_bus.sel;
        own_adr   = data_bus.adr;
        own_dat_w = data_bus.dat_w;
      end
      default: ;
    endcase
  end

  assign granted     = (state != ARB_IDLE);
  assign release_bus = granted && !own_cyc;
  // Re-arbitrate directly on release so a handover needs no idle cycle.
  assign arb_now     = !granted || release_bus;
  assign picked      = arb_pick(req_i, req_d, starved);

  always_comb begin
    next_state = state;
    if (expire) begin
      next_state = ARB_IDLE;
    end else if (arb_now) begin
      next_state = picked;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
    end else begin
      state <= next_state;
      if (arb_now && !expire) begin
        if (picked == ARB_INSTR) begin
          starve_cnt <= '0;
        end else if (picked == ARB_DATA && req_i && !starved) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end

  assign wd_en  = granted && own_stb && !mem_bus.ack && !mem_bus.err;
  assign wd_clr = !granted || release_bus || mem_bus.ack || mem_bus.err;

  bus_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (expire)
  );

  assign mem_bus.cyc   = own_cyc;
  assign mem_bus.stb   = own_stb && !expire;
  assign mem_bus.we    = own_we;
  assign mem_bus.sel   = own_sel;
  assign mem_bus.adr   = own_adr;
  assign mem_bus.dat_w = own_dat_w;

  assign instr_bus.ack   = (state == ARB_INSTR) && mem_bus.ack && !expire;
  assign instr_bus.err   = (state == ARB_INSTR) && (mem_bus.err || expire);
  assign instr_bus.dat_r = (state == ARB_INSTR) ? mem_bus.dat_r : '0;

  assign data_bus.ack    = (state == ARB_DATA) && mem_bus.ack && !expire;
  assign data_bus.err    = (state == ARB_DATA) && (mem_bus.err || expire);
  assign data_bus.dat_r  = (state == ARB_DATA) ? mem_bus.dat_r : '0;

  always_comb begin
    unique case (state)
      ARB_INSTR: grant = GRANT_INSTR;
      ARB_DATA:  grant = GRANT_DATA;
      default:   grant = GRANT_NONE;
    endcase
  end

  assign timeout = expire;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter: expected grants and slave
// responses are queued per cycle and checked by an independent monitor.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] grant;
  logic       timeout;
  int         cyc_n = 0;
  int         checks = 0;
  int         errors = 0;

  wishbone #(.XLEN(32)) ib ();
  wishbone #(.XLEN(32)) db ();
  wishbone #(.XLEN(32)) mb ();

  bus_arbiter #(
    .XLEN           (32),
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .instr_bus (ib),
    .data_bus  (db),
    .mem_bus   (mb),
    .grant     (grant),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic        iack;
    logic        ierr;
    logic [31:0] idat;
    logic        dack;
    logic        derr;
    logic [31:0] ddat;
    logic        to;
    logic        mstb;
  } obs_t;

  typedef struct { int cyc; obs_t v; } rsp_t;
  typedef struct { int cyc; logic [1:0] g; logic mcyc; } gnt_t;

  rsp_t rq[$];
  gnt_t gq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic obs_t mk(input logic iack, input logic ierr, input logic [31:0] idat,
                              input logic dack, input logic derr, input logic [31:0] ddat,
                              input logic to, input logic mstb);
    obs_t o;
    o.iack = iack; o.ierr = ierr; o.idat = idat;
    o.dack = dack; o.derr = derr; o.ddat = ddat;
    o.to   = to;   o.mstb = mstb;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_g(input logic [1:0] g, input logic mcyc);
    gnt_t e;
    e.cyc = cyc_n; e.g = g; e.mcyc = mcyc;
    gq.push_back(e);
  endtask

  task automatic exp_r(input obs_t v);
    rsp_t e;
    e.cyc = cyc_n; e.v = v;
    rq.push_back(e);
  endtask

  task automatic idle_inputs();
    ib.cyc = 0; ib.stb = 0; ib.we = 0; ib.sel = '1; ib.adr = '0; ib.dat_w = '0;
    db.cyc = 0; db.stb = 0; db.we = 0; db.sel = '1; db.adr = '0; db.dat_w = '0;
    mb.ack = 0; mb.err = 0; mb.dat_r = '0;
  endtask

  task automatic mem_rsp(input logic ack, input logic [31:0] dat);
    mb.ack = ack; mb.dat_r = dat;
  endtask

  // Monitor: grant checkpoints every cycle, responses whenever a slave sees ack/err.
  always @(negedge clk) begin
    obs_t a;
    while (gq.size() != 0 && gq[0].cyc < cyc_n) begin
      checks++; errors++;
      $display("FAIL grant_missed cycle=%0d", gq[0].cyc);
      void'(gq.pop_front());
    end
    if (gq.size() != 0 && gq[0].cyc == cyc_n) begin
      checks++;
      if (grant !== gq[0].g || mb.cyc !== gq[0].mcyc) begin
        errors++;
        $display("FAIL grant cycle=%0d got grant=%b mem_cyc=%b want grant=%b mem_cyc=%b",
                 cyc_n, grant, mb.cyc, gq[0].g, gq[0].mcyc);
      end
      void'(gq.pop_front());
    end
    while (rq.size() != 0 && rq[0].cyc < cyc_n) begin
      checks++; errors++;
      $display("FAIL rsp_missing cycle=%0d want %h", rq[0].cyc, rq[0].v);
      void'(rq.pop_front());
    end
    if (ib.ack === 1'b1 || ib.err === 1'b1 || db.ack === 1'b1 || db.err === 1'b1 ||
        timeout === 1'b1) begin
      a = mk(ib.ack, ib.err, ib.dat_r, db.ack, db.err, db.dat_r, timeout, mb.stb);
      checks++;
      if (rq.size() != 0 && rq[0].cyc == cyc_n) begin
        if (a !== rq[0].v) begin
          errors++;
          $display("FAIL rsp cycle=%0d got %h want %h", cyc_n, a, rq[0].v);
        end
        void'(rq.pop_front());
      end else begin
        errors++;
        $display("FAIL rsp_unexpected cycle=%0d got %h", cyc_n, a);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    int s;
    rst = 1'b1;
    idle_inputs();
    step(); exp_g(GRANT_NONE, 0);
    step(); rst = 1'b0; exp_g(GRANT_NONE, 0);

    // Single instruction read.
    step(); ib.cyc = 1; ib.stb = 1; ib.adr = 32'h100; exp_g(GRANT_NONE, 0);
    step(); exp_g(GRANT_INSTR, 1);
    step(); mem_rsp(1, 32'h13); exp_g(GRANT_INSTR, 1);
    exp_r(mk(1, 0, 32'h13, 0, 0, 0, 0, 1));
    step(); mem_rsp(0, 0); ib.cyc = 0; ib.stb = 0; exp_g(GRANT_INSTR, 0);
    step(); exp_g(GRANT_NONE, 0);

    // Data burst held across three beats, then direct handover to instr.
    step(); db.cyc = 1; db.stb = 1; db.adr = 32'h200; ib.cyc = 1; ib.stb = 1; ib.adr = 32'h104;
    exp_g(GRANT_NONE, 0);
    for (int b = 1; b <= 3; b++) begin
      logic [31:0] d;
      d = 32'hA0 + 32'(b);
      step(); mem_rsp(1, d); exp_g(GRANT_DATA, 1);
      exp_r(mk(0, 0, 0, 1, 0, d, 0, 1));
    end
    step(); mem_rsp(0, 0); db.cyc = 0; db.stb = 0; exp_g(GRANT_DATA, 0);
    step(); mem_rsp(1, 32'h55); exp_g(GRANT_INSTR, 1);
    exp_r(mk(1, 0, 32'h55, 0, 0, 0, 0, 1));
    step(); mem_rsp(0, 0); ib.cyc = 0; ib.stb = 0; exp_g(GRANT_INSTR, 0);
    step(); exp_g(GRANT_NONE, 0);

    // Unacknowledged store times out; pending instr fetch follows after IDLE.
    step(); db.cyc = 1; db.stb = 1; db.we = 1; db.adr = 32'h300; db.dat_w = 32'hDEAD;
    exp_g(GRANT_NONE, 0);
    step(); exp_g(GRANT_DATA, 1);
    step();
    step(); ib.cyc = 1; ib.stb = 1; ib.adr = 32'h108;
    repeat (4) step();
    step(); exp_g(GRANT_DATA, 1);
    exp_r(mk(0, 0, 0, 0, 1, 0, 1, 0));
    step(); db.cyc = 0; db.stb = 0; db.we = 0; exp_g(GRANT_NONE, 0);
    step(); mem_rsp(1, 32'h77); exp_g(GRANT_INSTR, 1);
    exp_r(mk(1, 0, 32'h77, 0, 0, 0, 0, 1));
    step(); mem_rsp(0, 0); ib.cyc = 0; ib.stb = 0; exp_g(GRANT_INSTR, 0);
    step(); exp_g(GRANT_NONE, 0);

    // Ack arrives on the last watchdog cycle: ack wins.
    step(); db.cyc = 1; db.stb = 1; db.adr = 32'h400; exp_g(GRANT_NONE, 0);
    step(); exp_g(GRANT_DATA, 1);
    repeat (6) step();
    step(); mem_rsp(1, 32'hABCD);
    exp_r(mk(0, 0, 0, 1, 0, 32'hABCD, 0, 1));
    step(); mem_rsp(0, 0); db.cyc = 0; db.stb = 0; exp_g(GRANT_DATA, 0);
    step(); exp_g(GRANT_NONE, 0);

    // Anti-starvation: four data grants while instr waits, then instr.
    step(); db.cyc = 1; db.stb = 1; ib.cyc = 1; ib.stb = 1; exp_g(GRANT_NONE, 0);
    s = cyc_n;
    for (int k = 0; k < 4; k++) begin
      step(); exp_g(GRANT_DATA, 1);
      repeat (6) step();
      step(); exp_r(mk(0, 0, 0, 0, 1, 0, 1, 0));
      step(); exp_g(GRANT_NONE, 0);
    end
    step(); mem_rsp(1, 32'h99); exp_g(GRANT_INSTR, 1);
    exp_r(mk(1, 0, 32'h99, 0, 0, 0, 0, 1));
    step(); mem_rsp(0, 0); ib.cyc = 0; ib.stb = 0; exp_g(GRANT_INSTR, 0);
    step(); mem_rsp(1, 32'h42); exp_g(GRANT_DATA, 1);
    exp_r(mk(0, 0, 0, 1, 0, 32'h42, 0, 1));
    step(); mem_rsp(0, 0); db.cyc = 0; db.stb = 0; exp_g(GRANT_DATA, 0);
    step(); exp_g(GRANT_NONE, 0);

    // Reset mid-transfer abandons the access; a late ack is not forwarded.
    step(); db.cyc = 1; db.stb = 1; db.adr = 32'h500; exp_g(GRANT_NONE, 0);
    step(); exp_g(GRANT_DATA, 1);
    step(); rst = 1'b1; exp_g(GRANT_DATA, 1);
    step(); rst = 1'b0; mem_rsp(1, 32'h66); exp_g(GRANT_NONE, 0);
    step(); mem_rsp(0, 0); exp_g(GRANT_DATA, 1);
    step(); mem_rsp(1, 32'h5); exp_r(mk(0, 0, 0, 1, 0, 32'h5, 0, 1));
    step(); mem_rsp(0, 0); db.cyc = 0; db.stb = 0; exp_g(GRANT_DATA, 0);
    step(); exp_g(GRANT_NONE, 0);

    repeat (3) step();
    if (s <= 0) begin
      checks++; errors++;
      $display("FAIL cycle_counter got=%0d want>0", s);
    end
    if (rq.size() != 0 || gq.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expectations got rsp=%0d grant=%0d want 0", rq.size(), gq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares one external Wishbone bus between the core's instruction port (`instr_bus`) and data port (`data_bus`). This lets the RV32IC core run from a single unified memory.
- Arbitration is data-priority with an anti-starvation limit for instruction fetch.
- A granted master holds the bus for its whole `cyc` burst.
- A watchdog returns `err` to a master whose access is never acknowledged.
- Sits between `core` and the memory/peripheral interconnect.

Parameters:
XLEN, 32, width of adr/dat on all three buses
STARVE_LIMIT, 4, max consecutive data grants issued while an instr request waits; min 1
TIMEOUT_CYCLES, 255, cycles of stb without ack/err before forced err; 0 disables watchdog

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
instr_bus  wishbone.SLAVE  XLEN  instruction requester (cyc, stb, we, sel, adr, dat_w in; dat_r, ack, err out)
data_bus  wishbone.SLAVE  XLEN  data requester, same signal set
mem_bus  wishbone.MASTER  XLEN  shared downstream bus
grant  output  2  current owner, one-hot: [0]=instr, [1]=data, 00=none
timeout  output  1  one-cycle pulse when watchdog fires

Behaviour:
- State machine states: ARB_IDLE, ARB_INSTR, ARB_DATA. The state register is the only grant source.
- Request definition: req_i = instr_bus.cyc & instr_bus.stb; req_d = data_bus.cyc & data_bus.stb.
- Arbitration function, evaluated from IDLE and on release:
  - both requesting: data wins unless starve_cnt == STARVE_LIMIT, then instr wins;
  - single requester wins;
  - none: IDLE.
- Latency: a request seen in IDLE in cycle N is granted from cycle N+1. mem_bus.cyc/stb follow the granted master combinationally from N+1.
- Hold: stay in ARB_INSTR/ARB_DATA while the owner's cyc=1, which covers multi-beat bursts.
- Release: the cycle the owner's cyc=0, the next state comes directly from the arbitration function, with no dead IDLE cycle. An instr→data handover therefore costs zero extra cycles.
- Routing while granted:
  - mem_bus cyc, stb, we, sel, adr, dat_w are copied from the owner;
  - mem_bus ack/err/dat_r are routed to the owner only;
  - the non-owner sees ack=0, err=0, dat_r=0.
- When not granted (IDLE): mem_bus cyc=stb=we=0, sel=0, adr=0, dat_w=0; both slaves see ack=err=0.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - increments on each transition into ARB_DATA while req_i=1;
  - resets to 0 on any entry into ARB_INSTR;
  - holds otherwise; saturates at STARVE_LIMIT.
- Watchdog wd_cnt:
  - counts cycles in a grant state with owner stb=1 and mem_bus ack=0, err=0;
  - clears on ack, err, release, or IDLE.
  - When wd_cnt reaches TIMEOUT_CYCLES-1 with still no ack/err:
    - that cycle: owner receives err=1 and ack=0 instead of the mem_bus response; mem_bus stb is forced to 0; timeout=1;
    - next state: IDLE, regardless of owner cyc;
    - the owner must drop cyc and is re-arbitrated normally.
- Simultaneous events:
  - ack on the same cycle as the watchdog limit: ack wins, no err, no timeout pulse;
  - mem_bus err is passed through unchanged and does not touch the watchdog beyond clearing it.
- Reset (rst=1 at a clock edge): state=ARB_IDLE, starve_cnt=0, wd_cnt=0. Consequently grant=00, timeout=0, all mem_bus control low, all slave ack/err low.
- Reset mid-transfer abandons the transfer; no ack is forwarded in the reset cycle's aftermath.

Decomposition:
- Package bus_arbiter_pkg:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_INSTR, ARB_DATA};
  - localparams GRANT_NONE/GRANT_INSTR/GRANT_DATA for the one-hot grant encoding.
- One sub-module, bus_watchdog: a parameterised saturating counter with clear/enable inputs and an expire output. It is instantiated once, with TIMEOUT_CYCLES=0 tying expire low.

Test Plan:
- Single instr read: req_i at cycle 0, slave acks at cycle 2 with dat_r=32'h0000_0013 → grant=01 from cycle 1; instr_bus.ack=1 and dat_r=32'h13 at cycle 2; data_bus.ack stays 0.
- Contention: req_i and req_d both high continuously, each access acked in 1 cycle, cyc dropped after ack, STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I…
- Burst hold: data master keeps cyc=1 across 3 acked beats while instr requests → grant stays 10 for all 3 beats; instr granted the cycle data cyc drops, with no IDLE cycle.
- Watchdog: TIMEOUT_CYCLES=8, data store never acked → data_bus.err=1 and timeout=1 exactly 8 cycles after grant; mem_bus.stb=0 that cycle; IDLE next; pending instr request granted the cycle after.
- Ack/timeout collision: ack arrives on the 8th cycle with TIMEOUT_CYCLES=8 → ack delivered, err=0, timeout=0.
- Reset mid-transfer: rst=1 while ARB_DATA with stb high → next cycle grant=00, mem_bus.cyc=0, starve_cnt=0; arbitration resumes the cycle after rst drops.
